// File: rtl/dirty_tracker_scan.sv
// dirty_tracker_scan
//   Dirty-bit tracker for the MIPS data memory. Every enabled write marks the
//   granule holding i_addr dirty. A scan engine walks all granules and streams
//   the base word address of each dirty one over a valid/ready handshake.
//
// Ports
//   i_clk, i_reset    clock, asynchronous active-high reset
//   i_addr            word address shared by write marking and the dirty query
//   i_ena, i_wea      memory enable / write enable; both high marks a granule
//   i_clear           synchronous clear of all bits and the count, aborts a scan
//   o_bit_sucio       dirty bit of the granule holding i_addr
//   i_scan_start      one-cycle request to start a scan (honoured in IDLE only)
//   o_scan_valid      o_scan_addr holds the base address of a dirty granule
//   o_scan_addr       granule base word address (index * GRANULE)
//   i_scan_ready      consumer accepts the current beat
//   o_scan_done       one-cycle pulse when a scan completes
//   o_busy            scan in progress
//   o_dirty_count     number of dirty granules
module dirty_tracker_scan #(
  parameter int RAM_DEPTH     = 1024,
  parameter int GRANULE       = 1,
  parameter bit CLEAR_ON_SCAN = 1'b1,
  localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int NUM_G  = RAM_DEPTH / GRANULE,
  localparam int G_W    = (NUM_G > 1) ? $clog2(NUM_G) : 1,
  localparam int CNT_W  = G_W + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_ena,
  input  logic              i_wea,
  input  logic              i_clear,
  output logic              o_bit_sucio,
  input  logic              i_scan_start,
  output logic              o_scan_valid,
  output logic [ADDR_W-1:0] o_scan_addr,
  input  logic              i_scan_ready,
  output logic              o_scan_done,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_dirty_count
);

  localparam int             GR_W   = $clog2(GRANULE);
  localparam logic [G_W-1:0] LAST_G = G_W'(NUM_G - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [G_W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_G-1:0]    bits_q, bits_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [G_W-1:0]      g_s;
  logic [ADDR_W-1:0]   scan_base_s;
  logic                wr_s;
  logic                hs_s;
  logic                inc_s;
  logic                scan_clr_s;

  assign g_s         = G_W'(i_addr >> GR_W);
  assign scan_base_s = ADDR_W'(idx_q) << GR_W;
  assign wr_s        = i_ena & i_wea;
  assign hs_s        = (state_q == S_EMIT) & i_scan_ready;
  // A new write only adds to the count when the granule was clean.
  assign inc_s       = wr_s & ~bits_q[g_s];
  // A write to the granule being handed over wins over the scan-clear.
  assign scan_clr_s  = hs_s & CLEAR_ON_SCAN & bits_q[idx_q] & ~(wr_s & (g_s == idx_q));

  // Dirty bit vector and dirty count next-state.
  always_comb begin
    bits_d  = bits_q;
    count_d = count_q;
    if (i_clear) begin
      bits_d  = {NUM_G{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      if (scan_clr_s) begin
        bits_d[idx_q] = 1'b0;
      end else begin
        bits_d[idx_q] = bits_q[idx_q];
      end
      if (wr_s) begin
        bits_d[g_s] = 1'b1;
      end else begin
        bits_d[g_s] = bits_d[g_s];
      end
      if (inc_s && !scan_clr_s) begin
        count_d = count_q + CNT_W'(1);
      end else if (!inc_s && scan_clr_s) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // Scan FSM next-state, index walk and emitted address.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    if (i_clear) begin
      state_d = S_IDLE;
      idx_d   = {G_W{1'b0}};
      addr_d  = {ADDR_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_scan_start) begin
            state_d = S_SCAN;
            idx_d   = {G_W{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SCAN: begin
          if (bits_q[idx_q]) begin
            state_d = S_EMIT;
            addr_d  = scan_base_s;
          end else if (idx_q == LAST_G) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + G_W'(1);
          end
        end
        S_EMIT: begin
          // Address is held stable until the consumer takes the beat.
          if (i_scan_ready) begin
            if (idx_q == LAST_G) begin
              state_d = S_DONE;
            end else begin
              state_d = S_SCAN;
              idx_d   = idx_q + G_W'(1);
            end
          end else begin
            state_d = S_EMIT;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = {G_W{1'b0}};
        end
      endcase
    end
  end

  // State, index, address, dirty bits and count registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      idx_q   <= {G_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      bits_q  <= {NUM_G{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      bits_q  <= bits_d;
      count_q <= count_d;
    end
  end

  assign o_bit_sucio   = bits_q[g_s];
  assign o_scan_valid  = (state_q == S_EMIT);
  assign o_scan_done   = (state_q == S_DONE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_scan_addr   = addr_q;
  assign o_dirty_count = count_q;

endmodule
